// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the unified instruction/data memory
// Holds the port B access-size encoding (RISC-V funct3), the port B state
// enum, and the size/alignment helpers used by the store path.
package mem_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bstate_e;

    function automatic logic size_legal(input logic [2:0] s);
        case (s)
            SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] s, input logic [1:0] off);
        case (s)
            SZ_H, SZ_HU: return off[0];
            SZ_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Byte lanes touched by an aligned access; unsigned sizes store like signed.
    function automatic logic [3:0] byte_en(input logic [2:0] s, input logic [1:0] off);
        case (s)
            SZ_B, SZ_BU: return 4'b0001 << off;
            SZ_H, SZ_HU: return 4'b0011 << off;
            SZ_W:        return 4'b1111;
            default:     return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/unified_mem_if.sv
// rtl/unified_mem_if.sv - fetch (A), data (B) and watch signals of unified_mem
// master: requester side (drives a_valid/a_addr and the b_req_* fields).
// slave:  memory side (drives a_rvalid/a_rdata, b_req_ready, b_rsp_*, watch_data).
interface unified_mem_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req_valid;
    logic              b_req_ready;
    logic              b_we;
    logic [2:0]        b_size;
    logic [ADDR_W+1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_rsp_valid;
    logic              b_rsp_err;
    logic [DATA_W-1:0] b_rdata;

    logic [DATA_W-1:0] watch_data;

    modport master (
        output a_valid, a_addr, b_req_valid, b_we, b_size, b_addr, b_wdata,
        input  a_rvalid, a_rdata, b_req_ready, b_rsp_valid, b_rsp_err, b_rdata, watch_data
    );

    modport slave (
        input  a_valid, a_addr, b_req_valid, b_we, b_size, b_addr, b_wdata,
        output a_rvalid, a_rdata, b_req_ready, b_rsp_valid, b_rsp_err, b_rdata, watch_data
    );
endinterface

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - selects and extends the loaded byte/halfword/word
// Ports: size (funct3), off (byte offset in word), word (raw memory word),
//        data (right-aligned, sign- or zero-extended result; 0 for illegal size).
import mem_pkg::*;

module mem_load_align (
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] data
);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        sh   = word >> {off, 3'b000};
        b    = sh[7:0];
        h    = sh[15:0];
        data = '0;
        case (size)
            SZ_B:    data = {{24{b[7]}}, b};
            SZ_H:    data = {{16{h[15]}}, h};
            SZ_W:    data = word;
            SZ_BU:   data = {24'b0, b};
            SZ_HU:   data = {16'b0, h};
            default: data = '0;
        endcase
    end
endmodule

// File: rtl/unified_mem.sv
// rtl/unified_mem.sv - unified memory: pipelined fetch port A, sized load/store port B
// Ports: clk, rst_n (sync, active-low), bus (unified_mem_if.slave):
//   A: a_valid/a_addr -> a_rvalid/a_rdata after RD_LAT cycles, one per cycle.
//   B: b_req_valid/b_req_ready handshake, b_we/b_size/b_addr/b_wdata request,
//      b_rsp_valid/b_rsp_err/b_rdata one-cycle response RD_LAT cycles later.
//   watch_data: combinational mem[WATCH_ADDR].
import mem_pkg::*;

module unified_mem #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int WATCH_ADDR = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    unified_mem_if.slave    bus
);
    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("unified_mem: DATA_W must be 32");
        end
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
            $error("unified_mem: RD_LAT must be 1..4");
        end
    endgenerate

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    assign bus.watch_data = mem[ADDR_W'(WATCH_ADDR)];

    // Port A: RD_LAT-deep valid/data pipeline. Data is zeroed on empty slots
    // so a_rdata reads 0 whenever a_rvalid is low.
    logic [RD_LAT-1:0] a_vld_q;
    logic [DATA_W-1:0] a_dat_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) a_dat_q[i] <= '0;
        end else begin
            a_vld_q[0] <= bus.a_valid;
            a_dat_q[0] <= bus.a_valid ? mem[bus.a_addr] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                a_vld_q[i] <= a_vld_q[i-1];
                a_dat_q[i] <= a_dat_q[i-1];
            end
        end
    end

    assign bus.a_rvalid = a_vld_q[RD_LAT-1];
    assign bus.a_rdata  = a_dat_q[RD_LAT-1];

    // Port B request decode
    bstate_e           state_q, state_d;
    logic [2:0]        cnt_q;
    logic              err_q, ld_q;
    logic [2:0]        size_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] ld_data;
    logic              rsp_last;

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        off;
    logic              req_err, accept, do_write;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata_sh;

    assign word_idx        = bus.b_addr[ADDR_W+1:2];
    assign off             = bus.b_addr[1:0];
    assign req_err         = !size_legal(bus.b_size) || misaligned(bus.b_size, off);
    assign bus.b_req_ready = rst_n && (state_q == ST_IDLE);
    assign accept          = bus.b_req_valid && bus.b_req_ready;
    assign do_write        = accept && bus.b_we && !req_err;
    assign be              = byte_en(bus.b_size, off);
    assign wdata_sh        = bus.b_wdata << {off, 3'b000};

    // Stores commit at the acceptance edge; the array itself is never reset.
    // Port A and the load capture read the pre-write value through NBA ordering.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            err_q  <= 1'b0;
            ld_q   <= 1'b0;
            size_q <= '0;
            off_q  <= '0;
            word_q <= '0;
        end else if (accept) begin
            cnt_q  <= 3'(RD_LAT - 1);
            err_q  <= req_err;
            ld_q   <= !bus.b_we && !req_err;
            size_q <= bus.b_size;
            off_q  <= off;
            word_q <= mem[word_idx];
        end else if (state_q == ST_BUSY && cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        rsp_last = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: begin
                if (cnt_q == 3'd0) begin
                    rsp_last = rst_n;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mem_load_align u_align (
        .size (size_q),
        .off  (off_q),
        .word (word_q),
        .data (ld_data)
    );

    assign bus.b_rsp_valid = rsp_last;
    assign bus.b_rsp_err   = rsp_last && err_q;
    assign bus.b_rdata     = (rsp_last && ld_q) ? ld_data : '0;

endmodule

// File: tb/tb_unified_mem.sv
// tb/tb_unified_mem.sv - directed self-checking bench for unified_mem
import mem_pkg::*;

module tb_unified_mem;
    logic clk = 1'b0;
    logic rst_n;
    logic rst3_n;
    int   vectors = 0;
    int   fails   = 0;

    always #5 clk = ~clk;

    unified_mem_if #(.ADDR_W(8), .DATA_W(32)) m2 ();
    unified_mem_if #(.ADDR_W(8), .DATA_W(32)) m3 ();

    unified_mem #(.ADDR_W(8), .DATA_W(32), .RD_LAT(2), .WATCH_ADDR(1)) u2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m2)
    );

    unified_mem #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3), .WATCH_ADDR(1)) u3 (
        .clk   (clk),
        .rst_n (rst3_n),
        .bus   (m3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Port B transaction on u2; call right after posedge+1. Returns after the
    // response cycle's closing edge (+1), with the FSM back in IDLE.
    task automatic b_op(input logic we, input logic [2:0] sz, input logic [9:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output logic busy_rdy);
        rd = 'x; er = 1'bx; lat = -1; busy_rdy = 1'bx;
        m2.b_req_valid = 1'b1; m2.b_we = we; m2.b_size = sz;
        m2.b_addr = addr; m2.b_wdata = wd;
        @(posedge clk); #1;
        m2.b_req_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) busy_rdy = m2.b_req_ready;
            if (m2.b_rsp_valid) begin
                rd = m2.b_rdata; er = m2.b_rsp_err; lat = i;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic a_fetch(input logic [7:0] addr, output logic [31:0] rd, output int lat);
        rd = 'x; lat = -1;
        m2.a_valid = 1'b1; m2.a_addr = addr;
        @(posedge clk); #1;
        m2.a_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (m2.a_rvalid) begin
                rd = m2.a_rdata; lat = i;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    logic [31:0] rd, rd_a, rd_b;
    logic        er, rdy, seen_rsp;
    int          lat;
    logic [31:0] exp_w [3];

    initial begin
        exp_w[0] = 32'h1111_1111; exp_w[1] = 32'h2222_2222; exp_w[2] = 32'h3333_3333;
        rst_n = 1'b0; rst3_n = 1'b0;
        m2.a_valid = 0; m2.a_addr = 0; m2.b_req_valid = 0; m2.b_we = 0;
        m2.b_size = 0; m2.b_addr = 0; m2.b_wdata = 0;
        m3.a_valid = 0; m3.a_addr = 0; m3.b_req_valid = 0; m3.b_we = 0;
        m3.b_size = 0; m3.b_addr = 0; m3.b_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready",  {31'b0, m2.b_req_ready}, 32'd0);
        chk("rst_arvld",  {31'b0, m2.a_rvalid},    32'd0);
        chk("rst_ardata", m2.a_rdata,              32'd0);
        chk("rst_bvld",   {31'b0, m2.b_rsp_valid}, 32'd0);
        chk("rst_berr",   {31'b0, m2.b_rsp_err},   32'd0);
        chk("rst_brdata", m2.b_rdata,              32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; rst3_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, m2.b_req_ready}, 32'd1);
        @(posedge clk); #1;

        // Seed words 0..2
        b_op(1'b1, SZ_W, 10'h000, 32'h1111_1111, rd, er, lat, rdy);
        chk("sw0_rdata", rd, 32'd0);
        chk("sw0_err",   {31'b0, er}, 32'd0);
        chk("sw0_lat",   lat, 32'd2);
        chk("busy_ready", {31'b0, rdy}, 32'd0);
        @(negedge clk);
        chk("rsp_one_pulse", {31'b0, m2.b_rsp_valid}, 32'd0);
        chk("idle_ready",    {31'b0, m2.b_req_ready}, 32'd1);
        @(posedge clk); #1;
        b_op(1'b1, SZ_W, 10'h004, 32'h2222_2222, rd, er, lat, rdy);
        b_op(1'b1, SZ_W, 10'h008, 32'h3333_3333, rd, er, lat, rdy);
        chk("watch_word1", m2.watch_data, 32'h2222_2222);

        // Back-to-back fetches at 0,1,2 with RD_LAT=2
        for (int c = 0; c < 6; c++) begin
            m2.a_valid = (c < 3);
            m2.a_addr  = (c < 3) ? 8'(c) : 8'd0;
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                chk($sformatf("pipe_vld_c%0d", c), {31'b0, m2.a_rvalid}, 32'd1);
                chk($sformatf("pipe_dat_c%0d", c), m2.a_rdata, exp_w[c-2]);
            end else begin
                chk($sformatf("pipe_vld_c%0d", c), {31'b0, m2.a_rvalid}, 32'd0);
                chk($sformatf("pipe_dat_c%0d", c), m2.a_rdata, 32'd0);
            end
            @(posedge clk); #1;
        end
        m2.a_valid = 1'b0;

        // Byte/halfword loads with sign and zero extension
        b_op(1'b1, SZ_W,  10'h010, 32'h80FF_7F01, rd, er, lat, rdy);
        b_op(1'b0, SZ_B,  10'h010, 32'd0, rd, er, lat, rdy); chk("lb_10",  rd, 32'h0000_0001);
        chk("lb_10_err", {31'b0, er}, 32'd0);
        b_op(1'b0, SZ_B,  10'h011, 32'd0, rd, er, lat, rdy); chk("lb_11",  rd, 32'h0000_007F);
        b_op(1'b0, SZ_B,  10'h013, 32'd0, rd, er, lat, rdy); chk("lb_13",  rd, 32'hFFFF_FF80);
        b_op(1'b0, SZ_BU, 10'h013, 32'd0, rd, er, lat, rdy); chk("lbu_13", rd, 32'h0000_0080);
        b_op(1'b0, SZ_H,  10'h012, 32'd0, rd, er, lat, rdy); chk("lh_12",  rd, 32'hFFFF_80FF);
        b_op(1'b0, SZ_HU, 10'h012, 32'd0, rd, er, lat, rdy); chk("lhu_12", rd, 32'h0000_80FF);
        b_op(1'b0, SZ_W,  10'h010, 32'd0, rd, er, lat, rdy); chk("lw_10",  rd, 32'h80FF_7F01);

        // Partial stores merge into the existing word
        b_op(1'b1, SZ_W, 10'h020, 32'h1122_3344, rd, er, lat, rdy);
        b_op(1'b1, SZ_H, 10'h022, 32'h0000_BEEF, rd, er, lat, rdy);
        b_op(1'b0, SZ_W, 10'h020, 32'd0, rd, er, lat, rdy); chk("sh_merge", rd, 32'hBEEF_3344);
        b_op(1'b0, SZ_H, 10'h022, 32'd0, rd, er, lat, rdy); chk("lh_22",    rd, 32'hFFFF_BEEF);
        b_op(1'b1, SZ_B, 10'h021, 32'h0000_00AA, rd, er, lat, rdy);
        b_op(1'b0, SZ_W, 10'h020, 32'd0, rd, er, lat, rdy); chk("sb_merge", rd, 32'hBEEF_AA44);

        // Misaligned and illegal-size accesses
        b_op(1'b0, SZ_W, 10'h006, 32'd0, rd, er, lat, rdy);
        chk("lw_mis_err", {31'b0, er}, 32'd1); chk("lw_mis_rd", rd, 32'd0);
        b_op(1'b1, SZ_H, 10'h005, 32'h0000_DEAD, rd, er, lat, rdy);
        chk("sh_mis_err", {31'b0, er}, 32'd1); chk("sh_mis_rd", rd, 32'd0);
        b_op(1'b0, SZ_W, 10'h004, 32'd0, rd, er, lat, rdy); chk("sh_mis_nowr", rd, 32'h2222_2222);
        b_op(1'b1, 3'b111, 10'h008, 32'hFFFF_FFFF, rd, er, lat, rdy);
        chk("ill_st_err", {31'b0, er}, 32'd1);
        b_op(1'b0, 3'b011, 10'h008, 32'd0, rd, er, lat, rdy);
        chk("ill_ld_err", {31'b0, er}, 32'd1); chk("ill_ld_rd", rd, 32'd0);
        b_op(1'b0, SZ_W, 10'h008, 32'd0, rd, er, lat, rdy); chk("ill_nowr", rd, 32'h3333_3333);

        // Same-cycle fetch and store to word 4: fetch sees the old word
        rd_a = 'x; rd_b = 'x;
        m2.a_valid = 1'b1; m2.a_addr = 8'd4;
        m2.b_req_valid = 1'b1; m2.b_we = 1'b1; m2.b_size = SZ_W;
        m2.b_addr = 10'h010; m2.b_wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        m2.a_valid = 1'b0; m2.b_req_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (m2.a_rvalid)    rd_a = m2.a_rdata;
            if (m2.b_rsp_valid) rd_b = m2.b_rdata;
            @(posedge clk); #1;
        end
        chk("rbw_old",   rd_a, 32'h80FF_7F01);
        chk("rbw_st_rd", rd_b, 32'd0);
        a_fetch(8'd4, rd, lat);
        chk("rbw_new",   rd, 32'hA5A5_A5A5);
        chk("fetch_lat", lat, 32'd2);

        // RD_LAT=3 instance: reset during BUSY drops the response, keeps the store
        m3.b_req_valid = 1'b1; m3.b_we = 1'b1; m3.b_size = SZ_W;
        m3.b_addr = 10'h020; m3.b_wdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        m3.b_req_valid = 1'b0;
        rst3_n = 1'b0;
        seen_rsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (m3.b_rsp_valid) seen_rsp = 1'b1;
            if (i == 1) chk("rst3_ready", {31'b0, m3.b_req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        chk("rst3_no_rsp", {31'b0, seen_rsp}, 32'd0);
        rst3_n = 1'b1;
        @(negedge clk);
        chk("rst3_ready_after", {31'b0, m3.b_req_ready}, 32'd1);
        chk("rst3_rsp_after",   {31'b0, m3.b_rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rd = 'x; lat = -1;
        m3.b_req_valid = 1'b1; m3.b_we = 1'b0; m3.b_size = SZ_W; m3.b_addr = 10'h020;
        @(posedge clk); #1;
        m3.b_req_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (m3.b_rsp_valid) begin
                rd = m3.b_rdata; lat = i;
                break;
            end
        end
        chk("rst3_store_kept", rd, 32'h5A5A_5A5A);
        chk("rst3_lat", lat, 32'd3);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
